jump_ctrl: RTL and testbench

Control-transfer sequencer for the small RISC-V core pipeline. It accepts resolved branch and jump outcomes from the jump decision unit in EX and sequences the front end: PC redirect, squashing of wrong-path instructions, load-use bubbles, memory-stall freezes and misaligned-target traps. It owns every `pc_sel`, stall and flush control that reaches IF, ID and EX.

---
 rtl/jump_ctrl.sv | 151 +++++++++++++++
 tb/tb_jump_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/jump_ctrl.sv
// Control-transfer sequencer: PC redirect, wrong-path squash, load-use bubble, mem-stall freeze, misaligned-target trap.
// Outputs decode combinationally from state and live inputs; pc_target is registered. Optional counter under JUMP_STATS_EN.
module jump_ctrl #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clk_en,
    input  logic            jump_valid,
    input  logic            jump_taken,
    input  logic [XLEN-1:0] jump_target,
    input  logic            load_use_hazard,
    input  logic            mem_stall,
    input  logic            trap_ack,
    output logic            pc_sel,
    output logic [XLEN-1:0] pc_target,
    output logic            stall_if,
    output logic            stall_id,
    output logic            flush_if_id,
    output logic            flush_id_ex,
    output logic            misalign_exc,
`ifdef JUMP_STATS_EN
    output logic [31:0]     jump_count,
    input  logic            jump_count_clr,
`endif
    output logic            busy
);

    typedef enum logic [1:0] {RUN, REDIRECT, SQUASH, TRAP} state_t;

    localparam logic [1:0] SQ_INIT = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    state_t            state_q, state_d;
    logic [1:0]        sq_cnt_q, sq_cnt_d;
    logic [XLEN-1:0]   pc_target_q, pc_target_d;

    logic advance;
    logic jump_take;
    logic misaligned;

    assign advance    = clk_en & ~mem_stall;
    assign jump_take  = jump_valid & jump_taken;
    assign misaligned = |jump_target[1:0];
    assign pc_target  = pc_target_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            sq_cnt_q    <= 2'd0;
            pc_target_q <= '0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            pc_target_q <= pc_target_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sq_cnt_d    = sq_cnt_q;
        pc_target_d = pc_target_q;
        if (advance) begin
            case (state_q)
                RUN: begin
                    // Misaligned targets are still captured so the trap handler can inspect them.
                    if (jump_take) begin
                        pc_target_d = jump_target;
                        state_d     = misaligned ? TRAP : REDIRECT;
                    end
                end
                REDIRECT: begin
                    if (FLUSH_CYCLES <= 1) begin
                        state_d = RUN;
                    end else begin
                        sq_cnt_d = SQ_INIT;
                        state_d  = SQUASH;
                    end
                end
                SQUASH: begin
                    if (sq_cnt_q == 2'd0) state_d = RUN;
                    else                  sq_cnt_d = sq_cnt_q - 2'd1;
                end
                TRAP: begin
                    if (trap_ack) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_comb begin
        pc_sel       = 1'b0;
        stall_if     = 1'b0;
        stall_id     = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        misalign_exc = 1'b0;
        busy         = (state_q != RUN);
        case (state_q)
            RUN: begin
                // A taken jump makes the ID instruction wrong-path, so its hazard is moot.
                if (load_use_hazard && !jump_take) begin
                    stall_if    = 1'b1;
                    stall_id    = 1'b1;
                    flush_id_ex = 1'b1;
                end
            end
            REDIRECT: begin
                pc_sel      = 1'b1;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
            end
            SQUASH: flush_if_id = 1'b1;
            TRAP: begin
                stall_if     = 1'b1;
                stall_id     = 1'b1;
                flush_id_ex  = 1'b1;
                misalign_exc = 1'b1;
            end
            default: ;
        endcase
        if (mem_stall) begin
            stall_if    = 1'b1;
            stall_id    = 1'b1;
            pc_sel      = 1'b0;
            flush_if_id = 1'b0;
            flush_id_ex = 1'b0;
        end
    end

`ifdef JUMP_STATS_EN
    logic [31:0] jump_count_q, jump_count_d;
    logic        redirect_evt;

    assign redirect_evt = advance && (state_q == RUN) && jump_take && !misaligned;
    assign jump_count   = jump_count_q;

    always_comb begin
        jump_count_d = jump_count_q;
        if (advance && jump_count_clr) jump_count_d = 32'd0;
        else if (redirect_evt)         jump_count_d = jump_count_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) jump_count_q <= 32'd0;
        else     jump_count_q <= jump_count_d;
    end
`endif

endmodule

// File: tb/tb_jump_ctrl.sv
// Directed-vector bench for jump_ctrl (FLUSH_CYCLES = 2); counter vectors only when JUMP_STATS_EN is defined.
module tb_jump_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic        jump_valid;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        load_use_hazard;
    logic        mem_stall;
    logic        trap_ack;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        stall_if;
    logic        stall_id;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        misalign_exc;
    logic        busy;
`ifdef JUMP_STATS_EN
    logic [31:0] jump_count;
    logic        jump_count_clr;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    jump_ctrl #(.XLEN(32), .FLUSH_CYCLES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .clk_en          (clk_en),
        .jump_valid      (jump_valid),
        .jump_taken      (jump_taken),
        .jump_target     (jump_target),
        .load_use_hazard (load_use_hazard),
        .mem_stall       (mem_stall),
        .trap_ack        (trap_ack),
        .pc_sel          (pc_sel),
        .pc_target       (pc_target),
        .stall_if        (stall_if),
        .stall_id        (stall_id),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .misalign_exc    (misalign_exc),
`ifdef JUMP_STATS_EN
        .jump_count      (jump_count),
        .jump_count_clr  (jump_count_clr),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Output bundle order: {pc_sel, stall_if, stall_id, flush_if_id, flush_id_ex, misalign_exc, busy}
    localparam logic [6:0] O_IDLE  = 7'b000_0000;
    localparam logic [6:0] O_LU    = 7'b011_0100;
    localparam logic [6:0] O_REDIR = 7'b100_1101;
    localparam logic [6:0] O_SQ    = 7'b000_1001;
    localparam logic [6:0] O_TRAP  = 7'b011_0111;
    localparam logic [6:0] O_MS_RD = 7'b011_0001;
    localparam logic [6:0] O_MS_TR = 7'b011_0011;

    function automatic logic [6:0] outs();
        return {pc_sel, stall_if, stall_id, flush_if_id, flush_id_ex, misalign_exc, busy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vec(input string tag, input logic [6:0] exp);
        #1;
        chk(tag, {25'd0, outs()}, {25'd0, exp});
    endtask

    task automatic idle_in();
        jump_valid = 0; jump_taken = 0; jump_target = '0;
        load_use_hazard = 0; mem_stall = 0; trap_ack = 0;
    endtask

    task automatic take(input logic [31:0] tgt);
        jump_valid = 1; jump_taken = 1; jump_target = tgt;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not end, want end before 50000");
        $fatal(1);
    end

    initial begin
        rst = 1; clk_en = 1; idle_in();
`ifdef JUMP_STATS_EN
        jump_count_clr = 0;
`endif
        vec("reset_outs", O_IDLE);
        chk("reset_pc_target", pc_target, 32'h0);
        load_use_hazard = 1;
        vec("reset_lu_live", O_LU);
        load_use_hazard = 0;
        tick();
        rst = 0;
        tick();

        // Aligned taken jump, two flush cycles.
        take(32'h0000_0100);
        vec("jump_cycle", O_IDLE);
        tick(); idle_in();
        vec("redirect", O_REDIR);
        chk("redirect_tgt", pc_target, 32'h100);
        tick();
        vec("squash", O_SQ);
        tick();
        vec("back_run", O_IDLE);

        // Load-use bubble alone.
        load_use_hazard = 1;
        vec("load_use", O_LU);
        tick(); load_use_hazard = 0;
        vec("after_lu", O_IDLE);

        // Not-taken jump has no effect.
        jump_valid = 1; jump_target = 32'h300;
        vec("not_taken", O_IDLE);
        tick(); idle_in();
        vec("not_taken_next", O_IDLE);
        chk("not_taken_tgt", pc_target, 32'h100);

        // Misaligned target traps; wrong-path jump during the trap is ignored.
        take(32'h0000_0102);
        tick(); idle_in();
        for (int i = 0; i < 5; i++) begin
            take(32'h0000_0400);
            vec($sformatf("trap_%0d", i), O_TRAP);
            tick();
        end
        idle_in();
        chk("trap_tgt", pc_target, 32'h102);
        mem_stall = 1;
        vec("trap_mem_stall", O_MS_TR);
        tick(); mem_stall = 0;
        trap_ack = 1;
        vec("trap_ack_cycle", O_TRAP);
        tick(); trap_ack = 0;
        vec("trap_exit", O_IDLE);

        // Taken jump beats a simultaneous load-use hazard.
        take(32'h0000_0200); load_use_hazard = 1;
        vec("jump_beats_lu", O_IDLE);
        tick(); idle_in();
        vec("lu_jump_redirect", O_REDIR);
        chk("lu_jump_tgt", pc_target, 32'h200);
        tick(); tick();
        vec("lu_jump_done", O_IDLE);

        // mem_stall held 3 cycles in REDIRECT; redirect replays once.
        take(32'h0000_0104);
        tick(); idle_in();
        mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            vec($sformatf("ms_redirect_%0d", i), O_MS_RD);
            tick();
        end
        mem_stall = 0;
        vec("ms_replay", O_REDIR);
        tick();
        vec("ms_replay_sq", O_SQ);
        tick();
        vec("ms_replay_done", O_IDLE);

        // clk_en low holds SQUASH.
        take(32'h0000_0108);
        tick(); idle_in();
        tick();
        clk_en = 0;
        vec("hold_sq_0", O_SQ);
        tick();
        vec("hold_sq_1", O_SQ);
        clk_en = 1;
        tick();
        vec("hold_sq_done", O_IDLE);

        // Asynchronous reset mid-SQUASH.
        take(32'h0000_010C);
        tick(); idle_in();
        tick();
        vec("pre_rst_sq", O_SQ);
        rst = 1;
        vec("rst_mid_sq", O_IDLE);
        chk("rst_mid_sq_tgt", pc_target, 32'h0);
        tick(); rst = 0;
        tick();
        vec("post_rst", O_IDLE);

`ifdef JUMP_STATS_EN
        chk("cnt_after_rst", jump_count, 32'd0);
        for (int i = 0; i < 3; i++) begin
            take(32'h0000_0100 + 32'(i) * 4);
            tick(); idle_in();
            tick(); tick();
        end
        chk("cnt_three", jump_count, 32'd3);
        force dut.jump_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.jump_count_q;
        take(32'h0000_0500);
        tick(); idle_in();
        chk("cnt_wrap", jump_count, 32'd0);
        tick(); tick();
        take(32'h0000_0600);
        tick(); idle_in();
        chk("cnt_one", jump_count, 32'd1);
        tick(); tick();
        take(32'h0000_0700); jump_count_clr = 1;
        tick(); idle_in(); jump_count_clr = 0;
        chk("cnt_clr_wins", jump_count, 32'd0);
        tick(); tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
